dht11_controller: RTL and testbench

- Drives the DHT11 single-wire humidity/temperature sensor and captures one 40-bit frame per request.
- Consumes the 10 us tick stream from the tick generator as its only timebase. All protocol timing is counted in those ticks.
- Decoded humidity and temperature bytes are presented to the downstream UART/FIFO formatting logic with a one-cycle valid pulse.

---
 rtl/dht11_controller.sv | 227 ++++++++++++++++++++++
 tb/tb_dht11_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_controller.sv
`timescale 1ns / 1ps
// DHT11 single-wire sensor controller.
// On a start request it pulls the line low for the host start pulse, releases it, follows the
// sensor response handshake and captures the 40-bit frame. When the checksum matches, the four
// data bytes are loaded onto the outputs with a one-clock valid pulse. A timeout or a bad checksum
// sets the sticky error flag instead. All protocol timing is counted in tick_10us pulses.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   tick_10us    one-clock timebase pulse every 10 us
//   start        level request, sampled only while idle
//   dht_io       open-drain sensor line (driven 0 or released)
//   humidity_int humidity integer byte of the last good frame
//   humidity_dec humidity decimal byte
//   temp_int     temperature integer byte
//   temp_dec     temperature decimal byte
//   valid        one-clock pulse when the data outputs update
//   busy         high whenever a read is in progress
//   error        sticky timeout/checksum flag, cleared when a new read starts
module dht11_controller #(
  parameter int unsigned START_LOW_TICKS = 1800,
  parameter int unsigned RELEASE_TICKS   = 3,
  parameter int unsigned TIMEOUT_TICKS   = 20,
  parameter int unsigned BIT_THRESH      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_10us,
  input  logic       start,
  inout  wire        dht_io,
  output logic [7:0] humidity_int,
  output logic [7:0] humidity_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       valid,
  output logic       busy,
  output logic       error
);

  localparam int unsigned MaxTicks = (START_LOW_TICKS > TIMEOUT_TICKS) ? START_LOW_TICKS :
                                                                         TIMEOUT_TICKS;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StRelease,
    StRespWait,
    StRespLow,
    StRespHigh,
    StBitLow,
    StBitHigh,
    StCheck
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [39:0]     shift_q, shift_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      hum_int_q, hum_int_d, hum_dec_q, hum_dec_d;
  logic [7:0]      tmp_int_q, tmp_int_d, tmp_dec_q, tmp_dec_d;
  logic            valid_q, valid_d;
  logic            error_q, error_d;

  // Line synchronizer; sync3_q holds the previous synchronized value for edge detection.
  // Resetting to 1 matches the idle pulled-up line so no edge is seen after reset.
  logic sync1_q, sync2_q, sync3_q;
  logic rise, fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= dht_io;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;
  assign fall = ~sync2_q & sync3_q;

  logic       timeout;
  logic [9:0] sum;
  logic       sum_ok;

  assign timeout = (cnt_q >= CntW'(TIMEOUT_TICKS));
  // Ten bits so the carry out of the byte sum is kept, then only the low byte is compared.
  assign sum     = 10'(shift_q[39:32]) + 10'(shift_q[31:24]) + 10'(shift_q[23:16]) +
                   10'(shift_q[15:8]);
  assign sum_ok  = (sum[7:0] == shift_q[7:0]);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    hum_int_d = hum_int_q;
    hum_dec_d = hum_dec_q;
    tmp_int_d = tmp_int_q;
    tmp_dec_d = tmp_dec_q;
    error_d   = error_q;
    valid_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StStart;
          error_d   = 1'b0;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntW'(START_LOW_TICKS)) state_d = StRelease;
      end
      StRelease: begin
        if (cnt_q == CntW'(RELEASE_TICKS)) state_d = StRespWait;
      end
      // In every wait-for-edge state an edge takes priority over a simultaneous timeout.
      StRespWait: begin
        if (fall) begin
          state_d = StRespLow;
        end else if (timeout) begin
          state_d = StIdle;
          error_d = 1'b1;
        end
      end
      StRespLow: begin
        if (rise) begin
          state_d = StRespHigh;
        end else if (timeout) begin
          state_d = StIdle;
          error_d = 1'b1;
        end
      end
      StRespHigh: begin
        if (fall) begin
          state_d = StBitLow;
        end else if (timeout) begin
          state_d = StIdle;
          error_d = 1'b1;
        end
      end
      StBitLow: begin
        if (rise) begin
          state_d = StBitHigh;
        end else if (timeout) begin
          state_d = StIdle;
          error_d = 1'b1;
        end
      end
      StBitHigh: begin
        if (fall) begin
          // High time in ticks decides the bit value; MSB of the frame arrives first.
          shift_d   = {shift_q[38:0], (cnt_q >= CntW'(BIT_THRESH))};
          bit_cnt_d = bit_cnt_q + 6'd1;
          state_d   = (bit_cnt_q == 6'd39) ? StCheck : StBitLow;
        end else if (timeout) begin
          state_d = StIdle;
          error_d = 1'b1;
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (sum_ok) begin
          hum_int_d = shift_q[39:32];
          hum_dec_d = shift_q[31:24];
          tmp_int_d = shift_q[23:16];
          tmp_dec_d = shift_q[15:8];
          valid_d   = 1'b1;
        end else begin
          error_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Tick counter restarts on every state change so each state times itself.
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (tick_10us) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      hum_int_q <= '0;
      hum_dec_q <= '0;
      tmp_int_q <= '0;
      tmp_dec_q <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      hum_int_q <= hum_int_d;
      hum_dec_q <= hum_dec_d;
      tmp_int_q <= tmp_int_d;
      tmp_dec_q <= tmp_dec_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  // Open drain: only ever pull low, otherwise leave the line to the pull-up.
  assign dht_io       = (state_q == StStart) ? 1'b0 : 1'bz;

  assign humidity_int = hum_int_q;
  assign humidity_dec = hum_dec_q;
  assign temp_int     = tmp_int_q;
  assign temp_dec     = tmp_dec_q;
  assign valid        = valid_q;
  assign error        = error_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_dht11_controller.sv
`timescale 1ns / 1ps
// Directed bench for dht11_controller: host start pulse timing, nominal decode, checksum
// failure and wrap, missing sensor timeout, bit-width threshold, start/reset robustness.
// The tick is sped up to one pulse every 4 clocks; sensor line changes are aligned just after a
// tick so each phase spans an exact number of ticks.
module tb_dht11_controller;

  localparam int TickPeriod = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_10us = 1'b0;
  logic       start = 1'b0;
  logic       sensor_low = 1'b0;
  wire        dht_io;
  logic [7:0] humidity_int, humidity_dec, temp_int, temp_dec;
  logic       valid, busy, error;

  int checks = 0;
  int errors = 0;

  int   valid_cnt = 0;
  int   valid_long = 0;
  int   valid_err = 0;
  logic fall_valid = 1'b0;
  logic valid_prev = 1'b0;
  logic busy_prev = 1'b0;
  int   tdiv = 0;

  dht11_controller dut (
    .clk         (clk),
    .reset       (reset),
    .tick_10us   (tick_10us),
    .start       (start),
    .dht_io      (dht_io),
    .humidity_int(humidity_int),
    .humidity_dec(humidity_dec),
    .temp_int    (temp_int),
    .temp_dec    (temp_dec),
    .valid       (valid),
    .busy        (busy),
    .error       (error)
  );

  assign dht_io = sensor_low ? 1'b0 : 1'bz;
  pullup (dht_io);

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tdiv      = (tdiv == TickPeriod - 1) ? 0 : tdiv + 1;
      tick_10us = (tdiv == 0);
    end
  end

  always @(negedge clk) begin
    if (valid) valid_cnt <= valid_cnt + 1;
    if (valid && valid_prev) valid_long <= valid_long + 1;
    if (valid && error) valid_err <= valid_err + 1;
    if (busy_prev && !busy) fall_valid <= valid;
    valid_prev <= valid;
    busy_prev  <= busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick_10us !== 1'b1);
    end
  endtask

  task automatic phase(input bit low, input int n);
    @(negedge clk);
    sensor_low = low;
    wait_ticks(n);
  endtask

  // Zeros alternate 20/40 us highs, ones alternate 70/50 us highs.
  task automatic send_bits(input logic [39:0] data, input int nbits, input bit toggle);
    for (int i = 0; i < nbits; i++) begin
      int w;
      w = data[39-i] ? ((i % 2 == 1) ? 5 : 7) : ((i % 2 == 1) ? 4 : 2);
      phase(1'b1, 5);
      @(negedge clk);
      sensor_low = 1'b0;
      if (toggle && i == 10) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_ticks(w);
    end
  endtask

  task automatic host_start(output int low_ticks);
    int guard;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    low_ticks = 0;
    guard     = 0;
    while (dht_io === 1'b0 && guard < 20000) begin
      if (tick_10us) low_ticks++;
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic sensor_frame(input logic [39:0] data, input bit toggle);
    phase(1'b0, 5);
    phase(1'b1, 8);
    phase(1'b0, 8);
    send_bits(data, 40, toggle);
    phase(1'b1, 5);
    @(negedge clk) sensor_low = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (dht_io !== 1'b1) begin errors++;
      $display("FAIL reset dht_io: got %b want 1 (released)", dht_io); end
    checks++; if ({humidity_int, humidity_dec, temp_int, temp_dec} !== 32'h0) begin errors++;
      $display("FAIL reset data: got %h want 00000000",
               {humidity_int, humidity_dec, temp_int, temp_dec}); end
    checks++; if ({valid, busy, error} !== 3'b000) begin errors++;
      $display("FAIL reset flags: got %b want 000", {valid, busy, error}); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_nominal();
    int lt, v0, l0;
    v0 = valid_cnt;
    l0 = valid_long;
    host_start(lt);
    sensor_frame(40'h37_00_19_05_55, 1'b0);
    checks++; if (lt != 1800) begin errors++;
      $display("FAIL nominal start_low: got %0d ticks want 1800", lt); end
    checks++; if (humidity_int !== 8'd55) begin errors++;
      $display("FAIL nominal humidity_int: got %0d want 55", humidity_int); end
    checks++; if (humidity_dec !== 8'd0) begin errors++;
      $display("FAIL nominal humidity_dec: got %0d want 0", humidity_dec); end
    checks++; if (temp_int !== 8'd25) begin errors++;
      $display("FAIL nominal temp_int: got %0d want 25", temp_int); end
    checks++; if (temp_dec !== 8'd5) begin errors++;
      $display("FAIL nominal temp_dec: got %0d want 5", temp_dec); end
    checks++; if (valid_cnt - v0 != 1) begin errors++;
      $display("FAIL nominal valid_count: got %0d want 1", valid_cnt - v0); end
    checks++; if (valid_long != l0) begin errors++;
      $display("FAIL nominal valid_width: got %0d long pulses want 0", valid_long - l0); end
    checks++; if (fall_valid !== 1'b1) begin errors++;
      $display("FAIL nominal busy_fall_with_valid: got %b want 1", fall_valid); end
    checks++; if ({busy, error} !== 2'b00) begin errors++;
      $display("FAIL nominal busy_error: got %b want 00", {busy, error}); end
  endtask

  task automatic test_checksum_fail();
    int lt, v0;
    v0 = valid_cnt;
    host_start(lt);
    sensor_frame(40'h37_00_19_05_56, 1'b0);
    checks++; if (error !== 1'b1) begin errors++;
      $display("FAIL cksum_fail error: got %b want 1", error); end
    checks++; if (valid_cnt != v0) begin errors++;
      $display("FAIL cksum_fail valid_count: got %0d want 0", valid_cnt - v0); end
    checks++; if ({humidity_int, humidity_dec, temp_int, temp_dec} !== 32'h37_00_19_05) begin
      errors++;
      $display("FAIL cksum_fail data_hold: got %h want 37001905",
               {humidity_int, humidity_dec, temp_int, temp_dec}); end
  endtask

  task automatic test_no_sensor();
    int lt, v0, n, guard;
    v0 = valid_cnt;
    host_start(lt);
    n     = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 2000) begin
      if (tick_10us) n++;
      @(negedge clk);
      guard++;
    end
    // 3 release ticks before response wait, then the 20-tick timeout.
    checks++; if (n != 23) begin errors++;
      $display("FAIL no_sensor timeout_ticks: got %0d want 23", n); end
    checks++; if ({busy, error} !== 2'b01) begin errors++;
      $display("FAIL no_sensor busy_error: got %b want 01", {busy, error}); end
    checks++; if (valid_cnt != v0) begin errors++;
      $display("FAIL no_sensor valid_count: got %0d want 0", valid_cnt - v0); end
  endtask

  // Byte pattern 0011 with this width scheme gives highs of 20, 40, 50, 70 us.
  task automatic test_bit_threshold();
    int lt, v0;
    v0 = valid_cnt;
    host_start(lt);
    checks++; if ({busy, error} !== 2'b10) begin errors++;
      $display("FAIL threshold error_cleared_on_start: got %b want 10", {busy, error}); end
    sensor_frame(40'h33_33_33_33_CC, 1'b0);
    checks++; if ({humidity_int, humidity_dec, temp_int, temp_dec} !== 32'h33_33_33_33) begin
      errors++;
      $display("FAIL threshold data: got %h want 33333333",
               {humidity_int, humidity_dec, temp_int, temp_dec}); end
    checks++; if (valid_cnt - v0 != 1 || error !== 1'b0) begin errors++;
      $display("FAIL threshold valid_error: got %0d/%b want 1/0", valid_cnt - v0, error); end
  endtask

  task automatic test_checksum_wrap_start_toggle();
    int lt, v0;
    v0 = valid_cnt;
    host_start(lt);
    sensor_frame(40'hFF_01_80_80_00, 1'b1);
    checks++; if ({humidity_int, humidity_dec, temp_int, temp_dec} !== 32'hFF_01_80_80) begin
      errors++;
      $display("FAIL wrap data: got %h want ff018080",
               {humidity_int, humidity_dec, temp_int, temp_dec}); end
    checks++; if (valid_cnt - v0 != 1) begin errors++;
      $display("FAIL wrap valid_count: got %0d want 1", valid_cnt - v0); end
    checks++; if ({busy, error} !== 2'b00) begin errors++;
      $display("FAIL wrap busy_error: got %b want 00", {busy, error}); end
  endtask

  task automatic test_reset_mid_frame();
    int lt;
    host_start(lt);
    phase(1'b0, 5);
    phase(1'b1, 8);
    phase(1'b0, 8);
    send_bits(40'h12_34_56_78_14, 17, 1'b0);
    phase(1'b1, 5);
    @(negedge clk) sensor_low = 1'b0;
    wait_ticks(2);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL midreset busy_before: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    checks++; if (dht_io !== 1'b1) begin errors++;
      $display("FAIL midreset dht_io: got %b want 1 (released)", dht_io); end
    checks++; if ({humidity_int, humidity_dec, temp_int, temp_dec} !== 32'h0) begin errors++;
      $display("FAIL midreset data: got %h want 00000000",
               {humidity_int, humidity_dec, temp_int, temp_dec}); end
    checks++; if ({valid, busy, error} !== 3'b000) begin errors++;
      $display("FAIL midreset flags: got %b want 000", {valid, busy, error}); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if ({busy, dht_io} !== 2'b01) begin errors++;
      $display("FAIL midreset idle_after: got %b want 01", {busy, dht_io}); end
  endtask

  task automatic test_back_to_back();
    int lt, v0;
    v0 = valid_cnt;
    host_start(lt);
    sensor_frame(40'h12_34_56_78_14, 1'b0);
    checks++; if (lt != 1800) begin errors++;
      $display("FAIL clean start_low: got %0d ticks want 1800", lt); end
    checks++; if ({humidity_int, humidity_dec, temp_int, temp_dec} !== 32'h12_34_56_78) begin
      errors++;
      $display("FAIL clean data: got %h want 12345678",
               {humidity_int, humidity_dec, temp_int, temp_dec}); end
    checks++; if (valid_cnt - v0 != 1 || error !== 1'b0) begin errors++;
      $display("FAIL clean valid_error: got %0d/%b want 1/0", valid_cnt - v0, error); end
    checks++; if (valid_err != 0) begin errors++;
      $display("FAIL valid_with_error: got %0d clocks want 0", valid_err); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_checksum_fail();
    test_no_sensor();
    test_bit_threshold();
    test_checksum_wrap_start_toggle();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
